multi_cycle_cpu: RTL and testbench

Multi-cycle successor to the single-cycle MIPS core: a subset-MIPS32 processor that shares one external memory port between instruction fetch and data access through a req/ack handshake, and tolerates any number of memory wait states. It contains its own 32×32 register file, ALU and sequencing FSM. It replaces the separate instruction/data memories of the single-cycle core. Retire and halt outputs make it self-checking in simulation.

---
 rtl/multi_cycle_cpu.sv | 125 ++++++++++++
 tb/tb_multi_cycle_cpu.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: subset-MIPS32 multi-cycle core sharing one req/ack memory port between fetch and data.
module multi_cycle_cpu #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        MemReq,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        Halted,
  output logic        RetireValid,
  output logic [31:0] RetirePC
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state;
  logic [31:0] pc, ir_pc, ir, a, b, res, target;
  logic [31:0] rf [32];
  logic [5:0] op, fn;
  logic [4:0] rs, rt, shamt, wreg;
  logic [31:0] simm, zimm, alu;
  logic is_r, r_add, r_sub, r_and, r_or, r_slt, r_sll, r_srl, r_jr;
  logic op_addi, op_andi, op_ori, op_lui, op_lw, op_sw, op_beq, op_bne, op_j, op_jal;
  logic legal, jump, branch, mem_op, take;
  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign shamt = ir[10:6];
  assign is_r = op == 6'h00;
  assign r_add = is_r && fn == 6'h20;
  assign r_sub = is_r && fn == 6'h22;
  assign r_and = is_r && fn == 6'h24;
  assign r_or = is_r && fn == 6'h25;
  assign r_slt = is_r && fn == 6'h2A;
  assign r_sll = is_r && fn == 6'h00;
  assign r_srl = is_r && fn == 6'h02;
  assign r_jr = is_r && fn == 6'h08;
  assign op_addi = op == 6'h08;
  assign op_andi = op == 6'h0C;
  assign op_ori = op == 6'h0D;
  assign op_lui = op == 6'h0F;
  assign op_lw = op == 6'h23;
  assign op_sw = op == 6'h2B;
  assign op_beq = op == 6'h04;
  assign op_bne = op == 6'h05;
  assign op_j = op == 6'h02;
  assign op_jal = op == 6'h03;
  assign legal = r_add | r_sub | r_and | r_or | r_slt | r_sll | r_srl | r_jr | op_addi | op_andi |
                 op_ori | op_lui | op_lw | op_sw | op_beq | op_bne | op_j | op_jal;
  assign jump = op_j | op_jal | r_jr;
  assign branch = op_beq | op_bne;
  assign mem_op = op_lw | op_sw;
  assign take = op_beq ? a == b : a != b;
  assign simm = {{16{ir[15]}}, ir[15:0]};
  assign zimm = {16'h0, ir[15:0]};
  assign wreg = is_r ? ir[15:11] : rt;
  assign alu = (r_add | op_addi | mem_op) ? a + (is_r ? b : simm) :
               r_sub ? a - b :
               r_and ? a & b :
               op_andi ? a & zimm :
               r_or ? a | b :
               op_ori ? a | zimm :
               r_slt ? {31'h0, $signed(a) < $signed(b)} :
               r_sll ? b << shamt :
               r_srl ? b >> shamt :
               {ir[15:0], 16'h0};
  // Memory-side outputs are combinational so an ack in the request's first cycle costs no wait state.
  assign MemReq = !Reset && (state == FETCH || state == MEM);
  assign MemWrite = !Reset && state == MEM && op_sw;
  assign MemAddr = Reset ? '0 : state == MEM ? res : pc;
  assign MemWData = b;
  assign Halted = !Reset && state == HALT;
  assign RetireValid = !Reset && ((state == DECODE && (jump || (!legal && !HALT_ON_ILLEGAL))) ||
                       (state == EXEC && branch) || (state == MEM && MemAck && op_sw) || state == WB);
  assign RetirePC = Reset ? '0 : ir_pc;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= FETCH;
      pc <= RESET_VECTOR;
      ir <= '0;
      ir_pc <= '0;
      a <= '0;
      b <= '0;
      res <= '0;
      target <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: if (MemAck) begin
          ir <= MemRData;
          ir_pc <= pc;
          pc <= pc + 32'd4;
          state <= DECODE;
        end
        DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
          target <= pc + (simm << 2);
          state <= !legal ? (HALT_ON_ILLEGAL ? HALT : FETCH) : jump ? FETCH : EXEC;
          if (op_j || op_jal) pc <= {pc[31:28], ir[25:0], 2'b00};
          if (r_jr) pc <= rf[rs];
          if (op_jal) rf[31] <= pc;
        end
        EXEC: begin
          res <= alu;
          if (branch && take) pc <= target;
          state <= branch ? FETCH : mem_op ? MEM : WB;
        end
        MEM: if (MemAck) begin
          if (op_lw) res <= MemRData;
          state <= op_sw ? FETCH : WB;
        end
        WB: begin
          if (wreg != 5'd0) rf[wreg] <= res;
          state <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: ISA-level reference interpreter plus wait-state memory responder driving multi_cycle_cpu.
module tb_multi_cycle_cpu;
  localparam logic [31:0] RV = 32'h100;
  logic Clock = 0, Reset = 1, MemAck = 0;
  logic MemReq, MemWrite, Halted, RetireValid;
  logic [31:0] MemAddr, MemWData, RetirePC, MemRData = 0;
  int total = 0, bad = 0, waits = 0, wcnt = 0;
  logic [31:0] mem [1024];
  logic [31:0] mm [1024];
  logic [31:0] regs [32];
  logic [31:0] prog [$];
  logic [31:0] mpc, q_addr, q_wd, rpc, maddr, st_addr, st_data;
  logic busy = 0, q_wr, rv, hl, mreq;
  int fns [7] = '{32, 34, 36, 37, 42, 0, 2};

  multi_cycle_cpu #(.RESET_VECTOR(RV), .HALT_ON_ILLEGAL(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck), .Halted(Halted),
    .RetireValid(RetireValid), .RetirePC(RetirePC));

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt, input int rd, input int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input int op, input logic [31:0] t);
    return {6'(op), t[27:2]};
  endfunction

  task automatic load();
    for (int i = 0; i < 1024; i++) begin mem[i] = 0; mm[i] = 0; end
    foreach (prog[i]) begin mem[64 + i] = prog[i]; mm[64 + i] = prog[i]; end
    for (int i = 0; i < 32; i++) regs[i] = 0;
    mpc = RV;
  endtask

  // Executes one instruction architecturally; latency counts every memory phase plus its wait states.
  task automatic model_step(output logic [31:0] epc, output int elat, output bit ill);
    logic [31:0] ins, a, b, si, zi, v, ea, nxt;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh, wr;
    ins = mm[mpc[11:2]];
    epc = mpc;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
    a = regs[rs]; b = regs[rt];
    si = {{16{ins[15]}}, ins[15:0]}; zi = {16'h0, ins[15:0]};
    ea = a + si;
    ill = 0; wr = 0; v = 0; nxt = mpc + 4; elat = 4 + waits;
    if (op == 0) begin
      wr = rd;
      case (fn)
        6'h20: v = a + b;
        6'h22: v = a - b;
        6'h24: v = a & b;
        6'h25: v = a | b;
        6'h2A: v = ($signed(a) < $signed(b)) ? 1 : 0;
        6'h00: v = b << sh;
        6'h02: v = b >> sh;
        6'h08: begin nxt = a; elat = 2 + waits; wr = 0; end
        default: ill = 1;
      endcase
    end else begin
      wr = rt;
      case (op)
        6'h08: v = a + si;
        6'h0C: v = a & zi;
        6'h0D: v = a | zi;
        6'h0F: v = {ins[15:0], 16'h0};
        6'h23: begin v = mm[ea[11:2]]; elat = 5 + 2 * waits; end
        6'h2B: begin mm[ea[11:2]] = b; wr = 0; elat = 4 + 2 * waits; end
        6'h04: begin if (a == b) nxt = mpc + 4 + (si << 2); wr = 0; elat = 3 + waits; end
        6'h05: begin if (a != b) nxt = mpc + 4 + (si << 2); wr = 0; elat = 3 + waits; end
        6'h02: begin nxt = {mpc[31:28] + 4'(0), ins[25:0], 2'b00}; wr = 0; elat = 2 + waits; end
        6'h03: begin nxt = {mpc[31:28], ins[25:0], 2'b00}; regs[31] = mpc + 4; wr = 0; elat = 2 + waits; end
        default: ill = 1;
      endcase
    end
    if (ill) wr = 0;
    if (wr != 0) regs[wr] = v;
    mpc = nxt;
  endtask

  // Called at a falling edge; services the memory port for one cycle and samples outputs.
  task automatic tick();
    #1;
    mreq = MemReq;
    maddr = MemAddr;
    if (MemReq) begin
      if (!busy) begin
        busy = 1; wcnt = 0; q_addr = MemAddr; q_wr = MemWrite; q_wd = MemWData;
      end else begin
        chk("addr_stable", MemAddr, q_addr);
        if (q_wr) chk("wdata_stable", MemWData, q_wd);
      end
      MemAck = (wcnt == waits);
      MemRData = mem[MemAddr[11:2]];
      if (MemAck) begin
        busy = 0;
        if (MemWrite) begin mem[MemAddr[11:2]] = MemWData; st_addr = MemAddr; st_data = MemWData; end
      end
      wcnt++;
    end else begin
      MemAck = 0;
      busy = 0;
    end
    #1;
    rv = RetireValid; rpc = RetirePC; hl = Halted;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1; MemAck = 0; busy = 0;
    @(posedge Clock);
    @(posedge Clock);
    @(negedge Clock);
    #1;
    chk("rst_memreq", MemReq, 0);
    chk("rst_memwrite", MemWrite, 0);
    chk("rst_retire", RetireValid, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_retirepc", RetirePC, 0);
    Reset = 0;
    #1;
    chk("first_req", MemReq, 1);
    chk("first_addr", MemAddr, RV);
  endtask

  task automatic run(input int n);
    logic [31:0] epc;
    int elat, c;
    bit ill;
    for (int k = 0; k < n; k++) begin
      model_step(epc, elat, ill);
      if (ill) break;
      c = 0;
      do begin tick(); c++; end while (!rv && c < 200);
      chk("retire_seen", 32'(rv), 1);
      chk("retire_pc", rpc, epc);
      chk("retire_lat", 32'(c), 32'(elat));
    end
  endtask

  task automatic check_state();
    for (int r = 1; r < 32; r++) chk($sformatf("reg%0d", r), dut.rf[r], regs[r]);
    for (int i = 0; i < 64; i++) chk($sformatf("dmem%0d", i), mem[i], mm[i]);
  endtask

  task automatic gen_rand(input int n);
    int k, rs, rt, rd;
    prog = {};
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 13);
      rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
      if (k < 7) prog.push_back(enc_r(fns[k], rs, rt, rd, $urandom_range(0, 31)));
      else if (k == 7) prog.push_back(enc_i(8, rs, rt, $urandom));
      else if (k == 8) prog.push_back(enc_i(12, rs, rt, $urandom));
      else if (k == 9) prog.push_back(enc_i(13, rs, rt, $urandom));
      else if (k == 10) prog.push_back(enc_i(15, 0, rt, $urandom));
      else if (k == 11) prog.push_back(enc_i(35, 0, rt, $urandom_range(0, 63) * 4));
      else if (k == 12) prog.push_back(enc_i(43, 0, rt, $urandom_range(0, 63) * 4));
      else prog.push_back(enc_i($urandom_range(4, 5), rs, rt, $urandom_range(0, 2)));
    end
    load();
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; mm[i] = mem[i]; end
  endtask

  initial begin
    logic [31:0] epc;
    int elat, c;
    bit ill;
    @(negedge Clock);
    prog = {enc_i(8, 0, 1, 5), enc_i(8, 0, 2, -3), enc_r(32, 1, 2, 3, 0), enc_r(42, 2, 1, 4, 0),
            enc_i(43, 0, 3, 0), enc_i(35, 0, 5, 0)};
    for (int w = 0; w < 4; w += 3) begin
      waits = w;
      load();
      do_reset();
      run(6);
      check_state();
      chk("r3", dut.rf[3], 2);
      chk("r4", dut.rf[4], 1);
      chk("r5", dut.rf[5], 2);
      chk("store_addr", st_addr, 0);
      chk("store_data", st_data, 2);
    end
    waits = 0;
    prog = {enc_i(8, 0, 1, 1), enc_i(4, 1, 1, 1), enc_i(8, 0, 2, 9), enc_i(5, 1, 1, 1),
            enc_j(3, 32'h120), enc_i(8, 0, 3, 3), 32'h0, 32'h0, enc_i(8, 0, 4, 4), enc_r(8, 31, 0, 0, 0)};
    load();
    do_reset();
    run(7);
    check_state();
    chk("jal_link", dut.rf[31], 32'h114);
    chk("beq_skipped", dut.rf[2], 0);
    waits = 1;
    prog = {enc_i(8, 0, 0, 7), enc_i(15, 0, 6, 16'h1234), enc_i(13, 6, 6, 16'h5678)};
    load();
    do_reset();
    run(3);
    check_state();
    chk("r0_zero", dut.rf[0], 0);
    chk("r6_lui_ori", dut.rf[6], 32'h1234_5678);
    for (int p = 0; p < 6; p++) begin
      waits = $urandom_range(0, 2);
      gen_rand(20);
      do_reset();
      run(24);
      check_state();
    end
    waits = 0;
    prog = {32'hFC00_0000};
    load();
    do_reset();
    model_step(epc, elat, ill);
    tick();
    chk("ill_fetch_halted", 32'(hl), 0);
    tick();
    chk("ill_decode_retire", 32'(rv), 0);
    chk("ill_decode_halted", 32'(hl), 0);
    tick();
    chk("ill_halted", 32'(hl), 32'(ill));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_memreq", 32'(mreq), 0);
      chk("halt_stays", 32'(hl), 1);
      chk("halt_retire", 32'(rv), 0);
    end
    waits = 3;
    prog = {enc_i(35, 0, 5, 0)};
    load();
    mem[0] = 32'hDEAD_BEEF;
    do_reset();
    c = 0;
    do begin tick(); c++; end while (!(mreq && maddr == 0) && c < 40);
    chk("mem_phase_seen", 32'(mreq && maddr == 0), 1);
    Reset = 1; MemAck = 0; busy = 0;
    #1;
    chk("midmem_rst_memreq", MemReq, 0);
    chk("midmem_rst_addr", MemAddr, 0);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 0;
    #1;
    chk("refetch_req", MemReq, 1);
    chk("refetch_addr", MemAddr, RV);
    chk("lw_abandoned", dut.rf[5], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
